// File: rtl/sram_uart_tx_interface_if.sv
// Control and SRAM read-port bundle for the UART transmit path.
// master: controller/SRAM side; slave: sram_uart_tx_interface.
//   Start, Start_address[17:0], Word_count[17:0]  block request
//   Busy, Done                                    block status
//   SRAM_address[17:0], SRAM_we_n, SRAM_read_data SRAM read port
interface sram_uart_tx_interface_if;
   logic        Start;
   logic [17:0] Start_address;
   logic [17:0] Word_count;
   logic        Busy;
   logic        Done;
   logic [17:0] SRAM_address;
   logic        SRAM_we_n;
   logic [15:0] SRAM_read_data;

   modport master (
      output Start,
      output Start_address,
      output Word_count,
      output SRAM_read_data,
      input  Busy,
      input  Done,
      input  SRAM_address,
      input  SRAM_we_n
   );

   modport slave (
      input  Start,
      input  Start_address,
      input  Word_count,
      input  SRAM_read_data,
      output Busy,
      output Done,
      output SRAM_address,
      output SRAM_we_n
   );
endinterface

// File: rtl/sram_uart_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends each as two 8N1 bytes,
// high byte first. Ports: Clock_50, Reset (async, high), bus (slave), UART_TX_O.
module sram_uart_tx_interface #(
   parameter int CLKS_PER_BIT  = 434,
   parameter int SRAM_READ_LAT = 2
) (
   input  logic Clock_50,
   input  logic Reset,
   sram_uart_tx_interface_if.slave bus,
   output logic UART_TX_O
);
   localparam int BW = $clog2(CLKS_PER_BIT + 1);
   localparam int LW = $clog2(SRAM_READ_LAT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(SRAM_READ_LAT - 1);

   typedef enum logic [2:0] {
      S_TX_IDLE,
      S_TX_READ,
      S_TX_WAIT,
      S_TX_LATCH,
      S_TX_START,
      S_TX_DATA,
      S_TX_STOP,
      S_TX_FINISH
   } state_t;

   state_t        state_q;
   logic [17:0]   cur_addr_q;
   logic [17:0]   remain_q;
   logic [17:0]   addr_q;
   logic [15:0]   word_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_q;
   logic          byte_sel_q;
   logic [BW-1:0] baud_q;
   logic [LW-1:0] wait_q;
   logic          tx_q;
   logic          busy_q;
   logic          done_q;

   logic [7:0]    byte_d;
   logic [17:0]   next_addr_d;
   logic          baud_end;

   assign byte_d      = byte_sel_q ? word_q[7:0] : word_q[15:8];
   assign next_addr_d = cur_addr_q + 18'd1;
   assign baud_end    = (baud_q == BAUD_LAST);

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_TX_IDLE;
         cur_addr_q <= '0;
         remain_q   <= '0;
         addr_q     <= '0;
         word_q     <= '0;
         shift_q    <= '0;
         bit_q      <= '0;
         byte_sel_q <= 1'b0;
         baud_q     <= '0;
         wait_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_TX_IDLE: begin
               // done_q still high here means Start coincides with Done
               if (bus.Start && !done_q) begin
                  busy_q     <= 1'b1;
                  remain_q   <= bus.Word_count;
                  cur_addr_q <= bus.Start_address;
                  if (bus.Word_count == 18'd0) begin
                     state_q <= S_TX_FINISH;
                  end else begin
                     addr_q  <= bus.Start_address;
                     state_q <= S_TX_READ;
                  end
               end
            end
            S_TX_READ: begin
               wait_q  <= '0;
               state_q <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (wait_q == LAT_LAST) begin
                  state_q <= S_TX_LATCH;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_TX_LATCH: begin
               word_q     <= bus.SRAM_read_data;
               byte_sel_q <= 1'b0;
               tx_q       <= 1'b0;
               state_q    <= S_TX_START;
            end
            S_TX_START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  tx_q    <= byte_d[0];
                  shift_q <= {1'b0, byte_d[7:1]};
                  bit_q   <= '0;
                  state_q <= S_TX_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_TX_DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_TX_STOP;
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_TX_STOP: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (!byte_sel_q) begin
                     // low byte follows with no idle gap
                     byte_sel_q <= 1'b1;
                     tx_q       <= 1'b0;
                     state_q    <= S_TX_START;
                  end else begin
                     cur_addr_q <= next_addr_d;
                     remain_q   <= remain_q - 18'd1;
                     if (remain_q == 18'd1) begin
                        state_q <= S_TX_FINISH;
                     end else begin
                        // SRAM_address keeps the last word read once idle
                        addr_q  <= next_addr_d;
                        state_q <= S_TX_READ;
                     end
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_TX_FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_TX_IDLE;
            end
         endcase
      end
   end

   assign bus.SRAM_address = addr_q;
   assign bus.SRAM_we_n    = 1'b1;
   assign bus.Busy         = busy_q;
   assign bus.Done         = done_q;
   assign UART_TX_O        = tx_q;
endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Scoreboard bench for sram_uart_tx_interface: UART decoder and Done
// monitor pop expected bytes/cycles pushed when each Start is issued.
module tb_sram_uart_tx_interface;
   localparam int CPB  = 4;
   localparam int LAT  = 2;
   localparam int WORD = LAT + 2 + 20 * CPB;

   typedef struct {
      logic [7:0] b;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   logic [15:0] mem [0:262143];
   logic [15:0] p1;
   exp_t        byte_q[$];
   int          done_q[$];

   sram_uart_tx_interface_if bus();

   sram_uart_tx_interface #(
      .CLKS_PER_BIT (CPB),
      .SRAM_READ_LAT(LAT)
   ) dut (
      .Clock_50 (clk),
      .Reset    (rst),
      .bus      (bus.slave),
      .UART_TX_O(tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // two-cycle read latency SRAM
   always @(posedge clk) begin
      p1                 <= mem[bus.SRAM_address];
      bus.SRAM_read_data <= p1;
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   // UART decoder: start bit seen at cycle s, bits sampled mid-cell
   always begin
      int         s;
      bit         ok;
      logic [7:0] bv;
      logic       stopb;
      exp_t       e;
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
         s     = cyc;
         ok    = 1'b1;
         bv    = '0;
         stopb = 1'b0;
         for (int i = 0; i < 9 && ok; i++) begin
            repeat (i == 0 ? 5 : 4) @(negedge clk);
            if (rst) ok = 1'b0;
            else if (i < 8) bv[i] = tx;
            else stopb = tx;
         end
         if (ok) begin
            if (byte_q.size() == 0) begin
               chk("uart_unexpected_byte", {24'd0, bv}, 32'hFFFF_FFFF);
            end else begin
               e = byte_q.pop_front();
               chk("uart_byte", {24'd0, bv}, {24'd0, e.b});
               chk("uart_start_cycle", s, e.cyc);
               chk("uart_stop_bit", {31'd0, stopb}, 32'd1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus.Done === 1'b1) begin
         if (done_q.size() == 0) begin
            chk("done_unexpected", cyc, 32'hFFFF_FFFF);
         end else begin
            chk("done_cycle", cyc, done_q.pop_front());
            chk("busy_at_done", {31'd0, bus.Busy}, 32'd0);
         end
      end
   end

   task automatic start_xfer(input logic [17:0] a, input int n,
                             input int max_b, input bit push_done,
                             output int c);
      exp_t        e;
      logic [17:0] ad;
      logic [15:0] w;
      int          nb;
      @(negedge clk);
      bus.Start         = 1'b1;
      bus.Start_address = a;
      bus.Word_count    = 18'(n);
      c  = cyc;
      nb = 0;
      for (int k = 0; k < n; k++) begin
         ad = a + 18'(k);
         w  = mem[ad];
         for (int b = 0; b < 2; b++) begin
            if (nb < max_b) begin
               e.b   = (b == 0) ? w[15:8] : w[7:0];
               e.cyc = c + LAT + 3 + k * WORD + b * 10 * CPB;
               byte_q.push_back(e);
               nb++;
            end
         end
      end
      if (push_done) done_q.push_back(c + 2 + n * WORD);
      @(negedge clk);
      bus.Start         = 1'b0;
      bus.Start_address = 18'h2AAAA;
      bus.Word_count    = 18'd7;
      chk("busy_rise", {31'd0, bus.Busy}, 32'd1);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while ((byte_q.size() != 0 || done_q.size() != 0 || bus.Busy)
             && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("drain_pending", byte_q.size() + done_q.size()
          + {31'd0, bus.Busy}, 32'd0);
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int bad;
      logic [17:0] a0;
      for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
      mem[18'h00100] = 16'hA55A;
      mem[18'h3FFFF] = 16'h1234;
      mem[18'h00000] = 16'hBEEF;
      mem[18'h00400] = 16'h0FF0;
      mem[18'h00401] = 16'h8001;
      mem[18'h00200] = 16'hC33C;
      mem[18'h00300] = 16'h7E81;
      bus.Start         = 1'b0;
      bus.Start_address = '0;
      bus.Word_count    = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_done", {31'd0, bus.Done}, 32'd0);
      chk("rst_we_n", {31'd0, bus.SRAM_we_n}, 32'd1);
      chk("rst_addr", {14'd0, bus.SRAM_address}, 32'd0);
      rst = 1'b0;

      // 1: quiet idle
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0
             || bus.SRAM_we_n !== 1'b1) bad++;
      end
      chk("idle_quiet", bad, 0);

      // 2: single word
      start_xfer(18'h00100, 1, 99, 1'b1, c);
      chk("addr_word0", {14'd0, bus.SRAM_address}, 32'h100);
      drain(400);

      // 3: address wrap
      start_xfer(18'h3FFFF, 2, 99, 1'b1, c);
      chk("addr_wrap0", {14'd0, bus.SRAM_address}, 32'h3FFFF);
      wait_cyc(c + 1 + WORD);
      chk("addr_wrap1", {14'd0, bus.SRAM_address}, 32'h00000);
      drain(400);

      // 4: zero count, then Start coincident with Done
      a0 = bus.SRAM_address;
      start_xfer(18'h00155, 0, 99, 1'b1, c);
      wait_cyc(c + 2);
      bus.Start         = 1'b1;
      bus.Start_address = 18'h00100;
      bus.Word_count    = 18'd1;
      @(negedge clk);
      bus.Start = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.Busy !== 1'b0 || tx !== 1'b1) bad++;
      end
      chk("start_at_done_ignored", bad, 0);
      chk("zero_count_addr", {14'd0, bus.SRAM_address}, {14'd0, a0});
      drain(50);

      // 5: extra Start while busy
      start_xfer(18'h00400, 2, 99, 1'b1, c);
      wait_cyc(c + 20);
      bus.Start         = 1'b1;
      bus.Start_address = 18'h00010;
      bus.Word_count    = 18'd3;
      @(negedge clk);
      bus.Start = 1'b0;
      drain(600);

      // 6: reset during data bits of byte 2
      start_xfer(18'h00200, 1, 1, 1'b0, c);
      wait_cyc(c + 55);
      rst = 1'b1;
      #1;
      chk("abort_tx_high", {31'd0, tx}, 32'd1);
      chk("abort_busy_low", {31'd0, bus.Busy}, 32'd0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      start_xfer(18'h00300, 1, 99, 1'b1, c);
      drain(400);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
